// File: rtl/kuznechik_stream_ctrl.sv
// ============================================================================
// Module   : kuznechik_stream_ctrl
// Purpose  : Packs a 32-bit word stream into 128-bit blocks for the Kuznechik
//            core, runs the req/ack handshake and streams the result back out.
// Revision : 1.0
// ============================================================================
`default_nettype none

module kuznechik_stream_ctrl #(
  parameter int WORD_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [WORD_W-1:0]     s_data_i,
  input  logic                  s_valid_i,
  output logic                  s_ready_o,
  output logic [WORD_W-1:0]     m_data_o,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic                  cipher_req_o,
  output logic                  cipher_ack_o,
  output logic [4*WORD_W-1:0]   cipher_data_o,
  input  logic                  cipher_busy_i,
  input  logic                  cipher_valid_i,
  input  logic [4*WORD_W-1:0]   cipher_data_i,
  output logic                  idle_o,
  output logic [CNT_W-1:0]      blocks_done_o
);

  localparam logic [2:0] c_FILL  = 3'd0;
  localparam logic [2:0] c_REQ   = 3'd1;
  localparam logic [2:0] c_WAIT  = 3'd2;
  localparam logic [2:0] c_ACK   = 3'd3;
  localparam logic [2:0] c_DRAIN = 3'd4;

  logic [2:0]            r_state;
  logic [1:0]            r_idx;
  logic [4*WORD_W-1:0]   r_in_buf;
  logic [4*WORD_W-1:0]   r_out_buf;
  logic                  r_req;
  logic                  r_ack;
  logic [CNT_W-1:0]      r_blocks;
  logic                  w_core_free;
  logic [WORD_W-1:0]     w_m_word;

  // A start request is only issued to a core that is neither computing nor
  // still presenting a previous result.
  assign w_core_free = ~cipher_busy_i & ~cipher_valid_i;

  always_comb begin
    w_m_word = '0;
    for (int i = 0; i < 4; i++) begin
      if (r_idx == i[1:0]) w_m_word = r_out_buf[i*WORD_W +: WORD_W];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= c_FILL;
      r_idx     <= 2'd0;
      r_in_buf  <= '0;
      r_out_buf <= '0;
      r_req     <= 1'b0;
      r_ack     <= 1'b0;
      r_blocks  <= '0;
    end else begin
      r_req <= 1'b0;
      r_ack <= 1'b0;
      case (r_state)
        c_FILL: begin
          if (s_valid_i) begin
            for (int i = 0; i < 4; i++) begin
              if (r_idx == i[1:0]) r_in_buf[i*WORD_W +: WORD_W] <= s_data_i;
            end
            r_idx <= r_idx + 2'd1;
            if (r_idx == 2'd3) begin
              r_state <= c_REQ;
              r_req   <= w_core_free;
            end
          end
        end
        c_REQ: begin
          if (r_req) begin
            r_state <= c_WAIT;
          end else if (w_core_free) begin
            r_req <= 1'b1;
          end
        end
        c_WAIT: begin
          if (cipher_valid_i) begin
            r_out_buf <= cipher_data_i;
            r_ack     <= 1'b1;
            r_state   <= c_ACK;
          end
        end
        c_ACK: begin
          r_state <= c_DRAIN;
        end
        c_DRAIN: begin
          if (m_ready_i) begin
            r_idx <= r_idx + 2'd1;
            if (r_idx == 2'd3) begin
              r_blocks <= r_blocks + CNT_W'(1);
              r_state  <= c_FILL;
            end
          end
        end
        default: begin
          r_state <= c_FILL;
          r_idx   <= 2'd0;
        end
      endcase
    end
  end

  assign s_ready_o     = (r_state == c_FILL);
  assign m_valid_o     = (r_state == c_DRAIN);
  assign m_data_o      = w_m_word;
  assign cipher_req_o  = r_req;
  assign cipher_ack_o  = r_ack;
  assign cipher_data_o = r_in_buf;
  assign idle_o        = (r_state == c_FILL) && (r_idx == 2'd0);
  assign blocks_done_o = r_blocks;

endmodule

`default_nettype wire

// File: tb/tb_kuznechik_stream_ctrl.sv
// ============================================================================
// Module   : tb_kuznechik_stream_ctrl
// Purpose  : Self-checking bench with a behavioural cipher core and a
//            transaction-level model of the stream front-end.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_kuznechik_stream_ctrl;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic [31:0]   s_data_i;
  logic          s_valid_i;
  logic          s_ready_o;
  logic [31:0]   m_data_o;
  logic          m_valid_o;
  logic          m_ready_i;
  logic          cipher_req_o;
  logic          cipher_ack_o;
  logic [127:0]  cipher_data_o;
  logic          cipher_busy_i;
  logic          cipher_valid_i;
  logic [127:0]  cipher_data_i;
  logic          idle_o;
  logic [15:0]   blocks_done_o;

  logic          w2_s_ready, w2_m_valid, w2_req, w2_ack, w2_idle;
  logic [31:0]   w2_m_data;
  logic [127:0]  w2_cdata;
  logic [1:0]    blocks_done_w2;

  always #5 clk_i = ~clk_i;

  kuznechik_stream_ctrl #(.WORD_W(32), .CNT_W(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .s_data_i(s_data_i), .s_valid_i(s_valid_i),
    .s_ready_o(s_ready_o), .m_data_o(m_data_o), .m_valid_o(m_valid_o),
    .m_ready_i(m_ready_i), .cipher_req_o(cipher_req_o), .cipher_ack_o(cipher_ack_o),
    .cipher_data_o(cipher_data_o), .cipher_busy_i(cipher_busy_i),
    .cipher_valid_i(cipher_valid_i), .cipher_data_i(cipher_data_i),
    .idle_o(idle_o), .blocks_done_o(blocks_done_o)
  );

  // Narrow-counter twin sharing all inputs, so counter wrap is reached quickly.
  kuznechik_stream_ctrl #(.WORD_W(32), .CNT_W(2)) dut_w2 (
    .clk_i(clk_i), .rst_i(rst_i), .s_data_i(s_data_i), .s_valid_i(s_valid_i),
    .s_ready_o(w2_s_ready), .m_data_o(w2_m_data), .m_valid_o(w2_m_valid),
    .m_ready_i(m_ready_i), .cipher_req_o(w2_req), .cipher_ack_o(w2_ack),
    .cipher_data_o(w2_cdata), .cipher_busy_i(cipher_busy_i),
    .cipher_valid_i(cipher_valid_i), .cipher_data_i(cipher_data_i),
    .idle_o(w2_idle), .blocks_done_o(blocks_done_w2)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural cipher core ----------------
  logic         core_valid = 1'b0;
  logic [127:0] core_data  = '0;
  logic [127:0] core_blk   = '0;
  int           core_cnt   = 0;
  int           core_lat   = 10;
  logic         busy_force = 1'b0;
  logic         stray_valid = 1'b0;

  assign cipher_valid_i = core_valid | stray_valid;
  assign cipher_busy_i  = (core_cnt > 0) | busy_force;
  assign cipher_data_i  = core_data;

  function automatic logic [127:0] cipher_fn(input logic [127:0] b);
    if (b == 128'h11223300_CCBBAA99_00FFEEDD_44556677)
      return 128'h7F679D90_BEBC2430_5A468D42_B9D4EDCD;
    return {b[95:0], b[127:96]} ^ 128'hA5A5_0F0F_3C3C_9696_5A5A_F0F0_C3C3_6969;
  endfunction

  initial begin
    logic sreq, sack, srst;
    logic [127:0] sblk;
    forever begin
      @(negedge clk_i);
      sreq = cipher_req_o; sack = cipher_ack_o; srst = rst_i; sblk = cipher_data_o;
      @(posedge clk_i); #1;
      if (srst) begin
        core_valid = 1'b0; core_cnt = 0;
      end else begin
        if (sack) core_valid = 1'b0;
        if (sreq) begin
          core_cnt = core_lat; core_blk = sblk;
        end else if (core_cnt > 0) begin
          core_cnt--;
          if (core_cnt == 0) begin
            core_valid = 1'b1; core_data = cipher_fn(core_blk);
          end
        end
      end
    end
  end

  // ---------------- sink ready driver ----------------
  int rdy_mode = 0;  // 0: always ready, 1: random 50%, 2: stalled
  initial begin
    m_ready_i = 1'b1;
    forever begin
      @(posedge clk_i); #1;
      case (rdy_mode)
        1:       m_ready_i = 1'($urandom_range(0, 1));
        2:       m_ready_i = 1'b0;
        default: m_ready_i = 1'b1;
      endcase
    end
  end

  // ---------------- transaction-level model + per-cycle compare ----------------
  logic         started = 1'b0;
  int           m_nin;
  logic         m_inflight, m_want_req, m_next_req, m_await, m_next_ack, m_drain;
  logic [127:0] m_inbuf;
  logic [31:0]  m_outq[$];
  logic [15:0]  m_blocks;
  int           req_cnt = 0;
  int           ack_cnt = 0;

  task automatic model_reset();
    m_nin = 0; m_inflight = 0; m_want_req = 0; m_next_req = 0; m_await = 0;
    m_next_ack = 0; m_drain = 0; m_inbuf = '0; m_outq.delete(); m_blocks = '0;
  endtask

  initial model_reset();

  always @(negedge clk_i) begin
    logic req_now, ack_now;
    if (started) begin
      chk("s_ready", 128'(s_ready_o), 128'(!m_inflight));
      chk("idle", 128'(idle_o), 128'(!m_inflight && m_nin == 0));
      chk("cipher_data", cipher_data_o, m_inbuf);
      chk("req", 128'(cipher_req_o), 128'(m_next_req));
      chk("ack", 128'(cipher_ack_o), 128'(m_next_ack));
      chk("m_valid", 128'(m_valid_o), 128'(m_drain));
      if (m_drain && m_outq.size() > 0) chk("m_data", 128'(m_data_o), 128'(m_outq[0]));
      chk("blocks_done", 128'(blocks_done_o), 128'(m_blocks));
      chk("blocks_done_w2", 128'(blocks_done_w2), 128'(m_blocks[1:0]));
    end
    if (cipher_req_o) req_cnt++;
    if (cipher_ack_o) ack_cnt++;
    if (rst_i) begin
      model_reset();
    end else begin
      req_now = m_next_req; ack_now = m_next_ack;
      m_next_req = 0; m_next_ack = 0;
      if (m_drain && m_ready_i && m_outq.size() > 0) begin
        void'(m_outq.pop_front());
        if (m_outq.size() == 0) begin
          m_drain = 0; m_inflight = 0; m_blocks = m_blocks + 16'd1;
        end
      end
      if (ack_now) m_drain = 1;
      if (m_await && cipher_valid_i) begin
        m_await = 0; m_next_ack = 1;
        for (int i = 0; i < 4; i++) m_outq.push_back(cipher_data_i[i*32 +: 32]);
      end
      if (req_now) begin
        m_want_req = 0; m_await = 1;
      end
      if (!m_inflight && s_valid_i) begin
        m_inbuf[m_nin*32 +: 32] = s_data_i;
        m_nin++;
        if (m_nin == 4) begin
          m_nin = 0; m_inflight = 1; m_want_req = 1;
        end
      end
      if (m_want_req && !cipher_busy_i && !cipher_valid_i) m_next_req = 1;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send_word(input logic [31:0] w);
    bit ok = 0;
    s_valid_i = 1'b1; s_data_i = w;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk_i);
      if (s_ready_o) begin ok = 1; break; end
    end
    if (!ok) begin
      errors++; checks++;
      $display("FAIL send_timeout: got no s_ready expected s_ready within 300 cycles");
    end
    @(posedge clk_i); #1;
    s_valid_i = 1'b0;
  endtask

  task automatic send_block(input logic [127:0] b, input bit gaps);
    for (int i = 0; i < 4; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk_i); #1; end
      send_word(b[i*32 +: 32]);
    end
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int t = 0; t < 500; t++) begin
      @(negedge clk_i);
      if (idle_o && !m_inflight) begin ok = 1; break; end
    end
    if (!ok) begin
      errors++; checks++;
      $display("FAIL idle_timeout: got busy expected idle within 500 cycles");
    end
    @(posedge clk_i); #1;
  endtask

  task automatic pulse_reset();
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0]  got[4];
    logic [31:0]  exp_out[4];
    logic [1:0]   exp_w2[5];
    logic [127:0] blk;
    int n, t, r0, a0;

    rst_i = 1'b1; s_valid_i = 1'b0; s_data_i = '0;
    repeat (2) @(posedge clk_i);
    #1; rst_i = 1'b0; started = 1'b1;

    @(negedge clk_i);
    chk("rst_s_ready", 128'(s_ready_o), 128'(1));
    chk("rst_m_valid", 128'(m_valid_o), 128'(0));
    chk("rst_idle", 128'(idle_o), 128'(1));
    chk("rst_m_data", 128'(m_data_o), 128'(0));
    chk("rst_cipher_data", cipher_data_o, 128'(0));
    chk("rst_blocks", 128'(blocks_done_o), 128'(0));
    @(posedge clk_i); #1;

    // Known vector through a 10-cycle core
    core_lat = 10; r0 = req_cnt; a0 = ack_cnt;
    send_block(128'h11223300_CCBBAA99_00FFEEDD_44556677, 0);
    t = 0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk_i);
      if (cipher_req_o) begin t = k; break; end
    end
    chk("t1_req_latency", 128'(t), 128'(1));
    chk("t1_block", cipher_data_o, 128'h11223300_CCBBAA99_00FFEEDD_44556677);
    n = 0;
    for (int k = 0; k < 100 && n < 4; k++) begin
      @(negedge clk_i);
      if (m_valid_o && m_ready_i) begin got[n] = m_data_o; n++; end
    end
    exp_out = '{32'hB9D4EDCD, 32'h5A468D42, 32'hBEBC2430, 32'h7F679D90};
    for (int i = 0; i < 4; i++) chk("t1_out_word", 128'(got[i]), 128'(exp_out[i]));
    repeat (2) @(negedge clk_i);
    chk("t1_blocks", 128'(blocks_done_o), 128'(1));
    chk("t1_req_count", 128'(req_cnt - r0), 128'(1));
    chk("t1_ack_count", 128'(ack_cnt - a0), 128'(1));
    @(posedge clk_i); #1;

    // Core busy for 20 cycles after the 4th word
    core_lat = 3;
    send_word(32'hDEAD0001); send_word(32'hDEAD0002); send_word(32'hDEAD0003);
    busy_force = 1'b1; r0 = req_cnt;
    send_word(32'hDEAD0004);
    repeat (20) @(posedge clk_i);
    #1;
    chk("busy_no_req", 128'(req_cnt - r0), 128'(0));
    busy_force = 1'b0;
    wait_idle();
    chk("busy_one_req", 128'(req_cnt - r0), 128'(1));

    // Random data, latency, gaps and sink back-pressure
    rdy_mode = 1;
    for (int b = 0; b < 8; b++) begin
      core_lat = $urandom_range(1, 6);
      blk = {$urandom, $urandom, $urandom, $urandom};
      send_block(blk, 1);
      wait_idle();
    end
    rdy_mode = 0;

    // Reset after two input words
    send_word(32'h0BAD0001); send_word(32'h0BAD0002);
    pulse_reset();
    send_block(128'h44444444_33333333_22222222_11111111, 0);
    t = 0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk_i);
      if (cipher_req_o) begin t = k; break; end
    end
    chk("rstfill_req", 128'(t), 128'(1));
    chk("rstfill_block", cipher_data_o, 128'h44444444_33333333_22222222_11111111);
    @(posedge clk_i); #1;
    wait_idle();

    // Reset in the middle of a stalled drain
    rdy_mode = 2;
    send_block(128'h0F0F0F0F_1E1E1E1E_2D2D2D2D_3C3C3C3C, 0);
    for (int k = 0; k < 100; k++) begin
      @(negedge clk_i);
      if (m_valid_o) break;
    end
    @(posedge clk_i); #1;
    a0 = ack_cnt;
    pulse_reset();
    @(negedge clk_i);
    chk("rstdrain_m_valid", 128'(m_valid_o), 128'(0));
    chk("rstdrain_m_data", 128'(m_data_o), 128'(0));
    rdy_mode = 0;
    repeat (5) @(negedge clk_i);
    chk("rstdrain_no_ack", 128'(ack_cnt - a0), 128'(0));
    @(posedge clk_i); #1;

    // Stray cipher_valid while filling
    a0 = ack_cnt;
    stray_valid = 1'b1;
    @(posedge clk_i); #1;
    stray_valid = 1'b0;
    repeat (3) @(negedge clk_i);
    chk("stray_no_ack", 128'(ack_cnt - a0), 128'(0));
    chk("stray_idle", 128'(idle_o), 128'(1));
    @(posedge clk_i); #1;

    // Counter wrap on the 2-bit twin, counted from a fresh reset
    pulse_reset();
    exp_w2 = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    core_lat = 2;
    for (int b = 0; b < 5; b++) begin
      send_block({$urandom, $urandom, $urandom, $urandom}, 0);
      wait_idle();
      chk("wrap_w2", 128'(blocks_done_w2), 128'(exp_w2[b]));
      chk("wrap_main", 128'(blocks_done_o), 128'(b + 1));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish before 2000000");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/kuznechik_stream_ctrl.md
# kuznechik_stream_ctrl

Streaming front-end for the Kuznechik cipher core. It accepts plaintext as a valid/ready stream of 32-bit words and packs four words into a 128-bit block. It drives the core's request/ack handshake, captures the 128-bit result and returns it as four 32-bit words on an output valid/ready stream. It sits directly upstream and downstream of the cipher core, as a DMA-friendly alternative to the register-mapped APB path.

## Interface
Parameters:
- WORD_W, 32, stream word width; fixed, only 32 supported.
- CNT_W, 16, width of the completed-block counter.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- s_data_i  in  32  input plaintext word.
- s_valid_i  in  1  input word valid.
- s_ready_o  out  1  block accepts input word.
- m_data_o  out  32  output ciphertext word.
- m_valid_o  out  1  output word valid.
- m_ready_i  in  1  sink accepts output word.
- cipher_req_o  out  1  one-cycle start pulse to the core.
- cipher_ack_o  out  1  one-cycle acknowledge pulse to the core.
- cipher_data_o  out  128  block to the core; held stable from req until valid seen.
- cipher_busy_i  in  1  core computing.
- cipher_valid_i  in  1  core result valid; held by the core until ack.
- cipher_data_i  in  128  core result.
- idle_o  out  1  FSM in FILL with zero words buffered.
- blocks_done_o  out  CNT_W  count of fully drained blocks; wraps modulo 2^CNT_W.

## Operation
- FSM states: FILL, REQ, WAIT, ACK, DRAIN.
- FILL:
  - s_ready_o=1.
  - Each s_valid_i&s_ready_o handshake writes the word into slot idx (word 0 -> bits [31:0], word 3 -> [127:96]) and increments the 2-bit word counter.
  - The handshake on word 3 moves to REQ, and the counter wraps to 0.
- REQ:
  - cipher_req_o=1 for exactly this cycle, then WAIT.
  - Entry to REQ is conditional on cipher_busy_i=0 and cipher_valid_i=0. Otherwise the FSM holds in REQ with cipher_req_o=0 until both are low.
- WAIT:
  - Hold until cipher_valid_i=1.
  - On that cycle, capture cipher_data_i into the output buffer and move to ACK.
- ACK: cipher_ack_o=1 for exactly this cycle, then DRAIN.
- DRAIN:
  - m_valid_o=1 with m_data_o = out_buf word[idx], word 0 first.
  - The counter advances on m_valid_o&m_ready_i.
  - The handshake on word 3 increments blocks_done_o and returns to FILL.
- s_ready_o=0 in every state except FILL. The input is not overlapped with the drain; the design is single-buffered.
- cipher_data_o is driven from the input buffer continuously. The input buffer is not written outside FILL.
- m_valid_o is never deasserted while m_ready_i=0. m_data_o is stable while m_valid_o=1 and m_ready_i=0.
- A cipher_valid_i pulse seen outside WAIT is ignored.

## Timing
- Reset values: state FILL, counters 0, buffers 0. Outputs: s_ready_o=1, m_valid_o=0, cipher_req_o=0, cipher_ack_o=0, idle_o=1, blocks_done_o=0, m_data_o=0, cipher_data_o=0.
- Reset asserted in any state forces the reset values on the next edge. A partially filled or partially drained block is discarded and no ack is issued.
- Ready core, back-to-back input:
  - 4th input handshake at edge N.
  - cipher_req_o high in cycle N+1.
  - Core asserts valid at edge V; cipher_ack_o high in cycle V+1.
  - m_valid_o first high in cycle V+2.
- With m_ready_i held high, the 4 output words take 4 cycles and FILL is re-entered in the cycle after the 4th output handshake.
- Minimum overhead per block, excluding core latency: 4 in + 1 req + 1 ack + 4 out cycles.
- cipher_req_o and cipher_ack_o are registered outputs, never high for two consecutive cycles, and never high simultaneously.
- blocks_done_o updates on the edge of the 4th output handshake. All-ones wraps to 0.

## Test plan
- Reset, then stream words 0x44556677, 0x00FFEEDD, 0xCCBBAA99, 0x11223300 -> cipher_data_o=0x11223300_CCBBAA99_00FFEEDD_44556677 and exactly one req pulse. The behavioural core returns 0x7F679D90_BEBC2430_5A468D42_B9D4EDCD after 10 cycles -> one ack pulse, then m_data_o sequence B9D4EDCD, 5A468D42, BEBC2430, 7F679D90, and blocks_done_o=1.
- Randomly toggle m_ready_i (50%) during DRAIN -> m_data_o stable while stalled, no word lost or duplicated, and s_ready_o=0 until the 4th word is taken.
- Hold cipher_busy_i=1 for 20 cycles after the 4th input word -> cipher_req_o stays 0 until busy falls, then a single pulse.
- Assert rst_i after 2 input words, then stream a new 4-word block -> the first two words are discarded and only the new block appears in cipher_data_o. Repeat with rst_i mid-DRAIN -> m_valid_o=0 next cycle and no ack.
- Preload the block counter at 0xFFFE and run 3 blocks -> blocks_done_o reads 0xFFFF, 0x0000, 0x0001.
- Pulse cipher_valid_i during FILL -> no capture, no ack, and the FSM stays in FILL.
